// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU result-side blocks.
//   XLEN_DEF   - default result width
//   RA_W_DEF   - default register address width
//   wb_entry_t - one write-back buffer entry {data, rd, valid}
package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef struct packed {
    logic [XLEN_DEF-1:0] data;
    logic [RA_W_DEF-1:0] rd;
    logic                valid;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_fwd_lookup.sv
// alu_wb_fwd_lookup: combinational forwarding lookup over the write-back
// buffer entries. The youngest valid entry whose rd matches addr wins;
// address 0 never hits; a miss returns hit=0, data=0.
// Ports:
//   entries - buffer storage (circular, indexed by pointer)
//   wptr    - write pointer; the entry just behind it is the youngest
//   addr    - operand register address to look up
//   hit     - a matching valid entry exists
//   data    - value of the youngest matching entry
module alu_wb_fwd_lookup
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     wptr,
  input  logic [RA_W-1:0]   addr,
  output logic              hit,
  output logic [XLEN-1:0]   data
);

  logic [PW-1:0] idx;

  // Walk from oldest slot (wptr) to youngest (wptr-1); later matches
  // override earlier ones, so the youngest match is what remains.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wptr - PW'(k);
      if (entries[idx].valid && (addr != '0) &&
          (entries[idx].rd == RA_W_DEF'(addr))) begin
        hit  = 1'b1;
        data = XLEN'(entries[idx].data);
      end
    end
  end

endmodule

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: in-order write-back FIFO between the ALU units and the
// register-file write port, with optional operand forwarding.
// Build option: define ALU_WB_FWD_EN to build the forwarding lookup;
// otherwise fwd_*_hit/fwd_*_data are tied to 0.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   flush                - discard all buffered entries
//   in_valid/in_ready    - ALU result handshake
//   in_result/in_rd/in_we- result, destination, write enable
//   out_valid/out_ready  - register-file write handshake
//   out_data/out_rd      - head entry (0 when empty)
//   count                - occupancy
//   fwd_rs*_addr/_hit/_data - operand forwarding lookups
module alu_wb_buffer
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 2,
  parameter int RA_W  = RA_W_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RA_W-1:0] out_rd,
  output logic [CW-1:0]   count,
  input  logic [RA_W-1:0] fwd_rs1_addr,
  input  logic [RA_W-1:0] fwd_rs2_addr,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data
);

  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          push, store, pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  // Beats that write nothing are acknowledged but never occupy a slot.
  assign store     = push && in_we && (in_rd != '0);
  assign pop       = out_valid && out_ready;

  assign out_data = out_valid ? XLEN'(entries[rptr].data) : '0;
  assign out_rd   = out_valid ? RA_W'(entries[rptr].rd)   : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (pop) begin
        entries[rptr].valid <= 1'b0;
        rptr                <= rptr + 1'b1;
      end
      if (store) begin
        entries[wptr] <= '{data:  XLEN_DEF'(in_result),
                           rd:    RA_W_DEF'(in_rd),
                           valid: 1'b1};
        wptr          <= wptr + 1'b1;
      end
      count <= count + CW'(store) - CW'(pop);
    end
  end

`ifdef ALU_WB_FWD_EN
  alu_wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .entries (entries),
    .wptr    (wptr),
    .addr    (fwd_rs1_addr),
    .hit     (fwd_rs1_hit),
    .data    (fwd_rs1_data)
  );

  alu_wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .entries (entries),
    .wptr    (wptr),
    .addr    (fwd_rs2_addr),
    .hit     (fwd_rs2_hit),
    .data    (fwd_rs2_data)
  );
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^{fwd_rs1_addr, fwd_rs2_addr};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb_alu_wb_buffer: directed self-checking bench for alu_wb_buffer
// (DEPTH=2). Forwarding expectations follow ALU_WB_FWD_EN.
`timescale 1ns/1ps
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_we;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  count;
  logic [4:0]  fwd_rs1_addr, fwd_rs2_addr;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef ALU_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  alu_wb_buffer #(.XLEN(32), .DEPTH(2), .RA_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_rd        (in_rd),
    .in_we        (in_we),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .count        (count),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic we);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    in_we     = we;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fwd_rs1_addr = 5'd0; fwd_rs2_addr = 5'd0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick(); tick();

    // Reset values
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_fwd1_hit", 32'(fwd_rs1_hit), 32'd0);
    chk("rst_fwd1_data", fwd_rs1_data, 32'd0);
    rst_n = 1'b1;

    // Single push, held through three stalled cycles
    drive(1'b1, 32'hFFFF_FFFE, 5'd5, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("push_out_valid", 32'(out_valid), 32'd1);
    chk("push_out_data", out_data, 32'hFFFF_FFFE);
    chk("push_out_rd", 32'(out_rd), 32'd5);
    chk("push_count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_data", out_data, 32'hFFFF_FFFE);
      chk("stall_out_rd", 32'(out_rd), 32'd5);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop1_count", 32'(count), 32'd0);
    chk("pop1_out_data", out_data, 32'd0);

    // Fill to full (write slots 1 then 0: pointer wrap), reject third beat
    drive(1'b1, 32'h33, 5'd3, 1'b1);
    tick();
    drive(1'b1, 32'h44, 5'd4, 1'b1);
    tick();
    chk("full_count", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h66, 5'd6, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("full_reject_count", 32'(count), 32'd2);
    chk("full_head_rd", 32'(out_rd), 32'd3);
    chk("full_head_data", out_data, 32'h33);
    out_ready = 1'b1;
    tick();
    chk("drain1_rd", 32'(out_rd), 32'd4);
    chk("drain1_data", out_data, 32'h44);
    chk("drain1_count", 32'(count), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("drain2_count", 32'(count), 32'd0);
    chk("drain2_out_valid", 32'(out_valid), 32'd0);

    // Non-writing beats are acknowledged but not stored
    drive(1'b1, 32'h77, 5'd0, 1'b1);
    chk("rd0_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h88, 5'd8, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("nowr_count", 32'(count), 32'd0);
    chk("nowr_out_valid", 32'(out_valid), 32'd0);

    // Simultaneous push and pop keeps count
    drive(1'b1, 32'hA, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'hB, 5'd2, 1'b1);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    out_ready = 1'b0;
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_rd", 32'(out_rd), 32'd2);
    chk("pushpop_data", out_data, 32'hB);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop_empty", 32'(count), 32'd0);

    // Forwarding: youngest of two matching entries wins
    drive(1'b1, 32'h10, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'h20, 5'd7, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    fwd_rs1_addr = 5'd7;
    fwd_rs2_addr = 5'd0;
    #1;
    chk("fwd1_hit", 32'(fwd_rs1_hit), FWD ? 32'd1 : 32'd0);
    chk("fwd1_data", fwd_rs1_data, FWD ? 32'h20 : 32'd0);
    chk("fwd2_addr0_hit", 32'(fwd_rs2_hit), 32'd0);
    chk("fwd2_addr0_data", fwd_rs2_data, 32'd0);
    fwd_rs2_addr = 5'd9;
    #1;
    chk("fwd2_miss_hit", 32'(fwd_rs2_hit), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fwd_after_pop_data", fwd_rs1_data, FWD ? 32'h20 : 32'd0);
    drive(1'b1, 32'h30, 5'd9, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("fwd2_new_hit", 32'(fwd_rs2_hit), FWD ? 32'd1 : 32'd0);
    chk("fwd2_new_data", fwd_rs2_data, FWD ? 32'h30 : 32'd0);

    // Reset while full
    chk("pre_rst_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_fwd1_hit", 32'(fwd_rs1_hit), 32'd0);

    // Flush with a concurrent push
    drive(1'b1, 32'h99, 5'd9, 1'b1);
    tick();
    chk("preflush_count", 32'(count), 32'd1);
    drive(1'b1, 32'hAA, 5'd10, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    fwd_rs1_addr = 5'd10;
    tick();
    chk("flush_beat_absent", 32'(count), 32'd0);
    chk("flush_fwd_miss", 32'(fwd_rs1_hit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
